// File: rtl/line_word_reader.sv
// Streams 16-bit words out of a captured 128-bit cache line, critical word first, wrapping within the line.
// Define LINE_WORD_READER_BYTE_MASK_EN to apply the captured byte-lane mask to the first beat of each burst.
module line_word_reader #(
  parameter int LINE_WORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [16*LINE_WORDS-1:0]  line_in,
  input  logic [2:0]                start_idx,
  input  logic [2:0]                len,
  input  logic [1:0]                byte_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               out_word,
  output logic [2:0]                out_idx,
  output logic                      out_last,
  output logic                      busy,
  output logic                      load_drop
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                    state_reg, state_next;
  logic [16*LINE_WORDS-1:0]  line_reg;
  logic [2:0]                idx_reg;
  logic [2:0]                remaining_reg;
  logic [15:0]               word_reg;
  logic                      drop_reg;

  logic accept, advance, fire, last_beat, drop;
  logic [15:0] first_word;

  function automatic logic [15:0] pick(input logic [16*LINE_WORDS-1:0] line, input logic [2:0] idx);
    return line[16*idx +: 16];
  endfunction

`ifdef LINE_WORD_READER_BYTE_MASK_EN
  always_comb begin
    first_word = pick(line_in, start_idx);
    case (byte_mask)
      2'b01:   first_word = {8'h00, first_word[7:0]};
      2'b10:   first_word = {first_word[15:8], 8'h00};
      default: first_word = pick(line_in, start_idx);
    endcase
  end
`else
  logic unused_mask;
  assign unused_mask = ^byte_mask;
  assign first_word  = pick(line_in, start_idx);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // A load is only taken when the slot is free or is being freed by the final handshake.
  always_comb begin
    state_next = state_reg;
    last_beat  = (state_reg == STREAM) && (remaining_reg == 3'd0);
    fire       = (state_reg == STREAM) && out_ready;
    accept     = load && ((state_reg == IDLE) || (fire && last_beat));
    advance    = fire && !last_beat;
    drop       = load && !accept;
    if (accept)
      state_next = STREAM;
    else if (fire && last_beat)
      state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg       <= 3'd0;
      remaining_reg <= 3'd0;
      word_reg      <= 16'h0000;
      drop_reg      <= 1'b0;
    end else begin
      drop_reg <= drop;
      if (accept) begin
        idx_reg       <= start_idx;
        remaining_reg <= len;
        word_reg      <= first_word;
      end else if (advance) begin
        idx_reg       <= idx_reg + 3'd1;
        remaining_reg <= remaining_reg - 3'd1;
        word_reg      <= pick(line_reg, idx_reg + 3'd1);
      end
    end
  end

  // Line contents are meaningless until a load, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (accept) line_reg <= line_in;
  end

  assign out_valid = (state_reg == STREAM);
  assign busy      = (state_reg == STREAM);
  assign out_last  = last_beat;
  assign out_word  = word_reg;
  assign out_idx   = idx_reg;
  assign load_drop = drop_reg;

endmodule

// File: tb/tb_line_word_reader.sv
// Self-checking bench for line_word_reader: table-driven bursts, hand-written corner sequences, random bursts vs a model.
// Honours LINE_WORD_READER_BYTE_MASK_EN the same way the design does.
module tb_line_word_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [127:0] line_in;
  logic [2:0]   start_idx;
  logic [2:0]   len_in;
  logic [1:0]   byte_mask;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_word;
  logic [2:0]   out_idx;
  logic         out_last;
  logic         busy;
  logic         load_drop;

  int vectors    = 0;
  int miscompares = 0;

  line_word_reader dut (
    .clk(clk), .rst_n(rst_n), .load(load), .line_in(line_in), .start_idx(start_idx),
    .len(len_in), .byte_mask(byte_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_idx(out_idx), .out_last(out_last), .busy(busy), .load_drop(load_drop)
  );

  always #5 clk = ~clk;

`ifdef LINE_WORD_READER_BYTE_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  typedef struct {
    int          start;
    int          len;
    logic [1:0]  mask;
    logic [15:0] first;
    logic [2:0]  last_idx;
  } vec_t;

  vec_t tbl[6];
  logic [127:0] pat;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] pattern_line();
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[16*k +: 16] = {8'hA0 + 8'(k), 8'h10 + 8'(k)};
    return l;
  endfunction

  // Beat b of a burst reads word (start+b) mod 8; only beat 0 honours the byte lanes.
  function automatic logic [15:0] exp_word(input logic [127:0] line, input int start, input int b, input logic [1:0] mask);
    logic [15:0] w;
    w = line[16*((start + b) % 8) +: 16];
    if (MASK_EN && b == 0) begin
      if (mask == 2'b01) w = {8'h00, w[7:0]};
      else if (mask == 2'b10) w = {w[15:8], 8'h00};
    end
    return w;
  endfunction

  // Called on a negedge; issues one load and follows the burst to the end while checking every cycle.
  task automatic run_burst(input logic [127:0] line, input int start, input int len, input logic [1:0] mask,
                           input int ready_pct, input int drop_pct,
                           output logic [15:0] first_seen, output logic [2:0] last_seen);
    int b = 0;
    int cycles = 0;
    bit r, ld, prev_drop;
    prev_drop = 1'b0;
    first_seen = '0;
    last_seen = '0;
    load = 1'b1; line_in = line; start_idx = 3'(start); len_in = 3'(len); byte_mask = mask; out_ready = 1'b0;
    @(negedge clk);
    load = 1'b0;
    while (b <= len && cycles < 200) begin
      check("valid", {31'd0, out_valid}, 1);
      check("busy", {31'd0, busy}, 1);
      check("idx", {29'd0, out_idx}, 32'((start + b) % 8));
      check("word", {16'd0, out_word}, {16'd0, exp_word(line, start, b, mask)});
      check("last", {31'd0, out_last}, {31'd0, (b == len)});
      check("load_drop", {31'd0, load_drop}, {31'd0, prev_drop});
      if (b == 0) first_seen = out_word;
      if (b == len) last_seen = out_idx;
      r  = ($urandom_range(99) < ready_pct);
      ld = ($urandom_range(99) < drop_pct);
      if (r && b == len) ld = 1'b0;
      out_ready = r; load = ld;
      line_in = {$urandom, $urandom, $urandom, $urandom};
      start_idx = 3'($urandom); len_in = 3'($urandom); byte_mask = 2'($urandom);
      prev_drop = ld;
      @(negedge clk);
      if (r) b++;
      cycles++;
    end
    if (cycles >= 200) begin
      vectors++; miscompares++;
      $display("FAIL burst_timeout: got %0d beats expected %0d", b, len + 1);
    end
    load = 1'b0; out_ready = 1'b0;
    check("idle_valid", {31'd0, out_valid}, 0);
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_drop", {31'd0, load_drop}, {31'd0, prev_drop});
    $display("burst start=%0d len=%0d mask=%0d cycles=%0d first=%h", start, len, mask, cycles, first_seen);
  endtask

  initial begin
    logic [15:0] fw;
    logic [2:0]  li;
    pat = pattern_line();
    tbl[0] = '{5, 7, 2'b00, 16'hA515, 3'd4};
    tbl[1] = '{6, 3, 2'b00, 16'hA616, 3'd1};
    tbl[2] = '{3, 1, 2'b10, (MASK_EN ? 16'hA300 : 16'hA313), 3'd4};
    tbl[3] = '{3, 0, 2'b01, (MASK_EN ? 16'h0013 : 16'hA313), 3'd3};
    tbl[4] = '{0, 7, 2'b11, 16'hA010, 3'd7};
    tbl[5] = '{7, 0, 2'b00, 16'hA717, 3'd7};

    rst_n = 1'b0; load = 1'b0; out_ready = 1'b0; line_in = '0; start_idx = '0; len_in = '0; byte_mask = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_word", {16'd0, out_word}, 0);
    check("rst_idx", {29'd0, out_idx}, 0);
    check("rst_last", {31'd0, out_last}, 0);
    check("rst_drop", {31'd0, load_drop}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_burst(pat, tbl[i].start, tbl[i].len, tbl[i].mask, 100, 0, fw, li);
      check("tbl_first", {16'd0, fw}, {16'd0, tbl[i].first});
      check("tbl_last_idx", {29'd0, li}, {29'd0, tbl[i].last_idx});
    end

    // Backpressure: stall on beat 2 for three cycles.
    load = 1'b1; line_in = pat; start_idx = 3'd1; len_in = 3'd2; byte_mask = 2'b00; out_ready = 1'b1;
    @(negedge clk); load = 1'b0;
    check("bp_idx0", {29'd0, out_idx}, 1);
    @(negedge clk); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_hold_word", {16'd0, out_word}, 32'hA212);
      check("bp_hold_idx", {29'd0, out_idx}, 2);
      check("bp_hold_last", {31'd0, out_last}, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idx3", {29'd0, out_idx}, 3);
    check("bp_last3", {31'd0, out_last}, 1);
    check("bp_word3", {16'd0, out_word}, 32'hA313);
    @(negedge clk);
    check("bp_idle", {31'd0, out_valid}, 0);
    out_ready = 1'b0;
    $display("backpressure sequence done");

    // Back-to-back: burst B loaded on the last handshake of burst A.
    load = 1'b1; line_in = pat; start_idx = 3'd0; len_in = 3'd0; byte_mask = 2'b00;
    @(negedge clk);
    check("b2b_a_idx", {29'd0, out_idx}, 0);
    check("b2b_a_last", {31'd0, out_last}, 1);
    load = 1'b1; start_idx = 3'd7; len_in = 3'd1; out_ready = 1'b1;
    @(negedge clk); load = 1'b0;
    check("b2b_b_valid", {31'd0, out_valid}, 1);
    check("b2b_b_idx7", {29'd0, out_idx}, 7);
    check("b2b_b_word7", {16'd0, out_word}, 32'hA717);
    check("b2b_no_drop", {31'd0, load_drop}, 0);
    @(negedge clk);
    check("b2b_b_idx0", {29'd0, out_idx}, 0);
    check("b2b_b_last", {31'd0, out_last}, 1);
    @(negedge clk);
    check("b2b_idle", {31'd0, out_valid}, 0);
    $display("back-to-back sequence done");

    // Mid-burst load must be dropped without disturbing the burst.
    load = 1'b1; line_in = pat; start_idx = 3'd0; len_in = 3'd3;
    @(negedge clk);
    load = 1'b1; line_in = '1; start_idx = 3'd5; len_in = 3'd0;
    @(negedge clk); load = 1'b0;
    check("drop_pulse", {31'd0, load_drop}, 1);
    check("drop_idx1", {29'd0, out_idx}, 1);
    check("drop_word1", {16'd0, out_word}, 32'hA111);
    @(negedge clk);
    check("drop_pulse_end", {31'd0, load_drop}, 0);
    check("drop_word2", {16'd0, out_word}, 32'hA212);
    repeat (2) @(negedge clk);
    check("drop_idle", {31'd0, out_valid}, 0);
    out_ready = 1'b0;
    $display("load drop sequence done");

    // Reset during the third beat aborts the burst.
    load = 1'b1; line_in = pat; start_idx = 3'd2; len_in = 3'd7; out_ready = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_idx", {29'd0, out_idx}, 4);
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", {31'd0, out_valid}, 0);
    check("rstmid_busy", {31'd0, busy}, 0);
    check("rstmid_last", {31'd0, out_last}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_stay_idle", {31'd0, out_valid}, 0);
    end
    out_ready = 1'b0;
    $display("reset mid-burst sequence done");

    for (int n = 0; n < 40; n++) begin
      run_burst({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(7)), int'($urandom_range(7)),
                2'($urandom), 60, 20, fw, li);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_word_reader.md
Name: line_word_reader

Overview:
- Read-side counterpart of the cache line write-merge path: it streams words out of a 128-bit cache line instead of merging a word in.
- Captures one lc3b_line plus a starting word index. Emits a burst of 16-bit words, critical-word-first, wrapping within the line, over a valid/ready handshake.
- Sits between the cache data array and any word-wide consumer: the CPU read-response path, or the writeback serializer toward physical memory.
- Applies the same 2-bit byte-lane convention to the critical word as the write path: 01 = low byte, 10 = high byte.

Parameters:
- LINE_WORDS, 8, words per line; fixed by lc3b_line / lc3b_index. Only 8 is supported.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  capture request.
- line_in  in  128  lc3b_line to stream.
- start_idx  in  3  lc3b_index of the first (critical) word.
- len  in  3  burst length minus 1 (0 = 1 word, 7 = whole line).
- byte_mask  in  2  lc3b_mem_wmask for the critical word.
- out_valid  out  1  out_word is valid.
- out_ready  in  1  consumer accepts the beat.
- out_word  out  16  current word.
- out_idx  out  3  word index of out_word within the line.
- out_last  out  1  current beat is the final beat.
- busy  out  1  a burst is in progress.
- load_drop  out  1  one-cycle pulse: a load was ignored.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_word=0, out_idx=0, out_last=0, busy=0, load_drop=0. Line buffer contents are don't-care.
- A reset assertion mid-burst aborts the burst immediately; no further beats are emitted.
- State machine, two states:
  - IDLE: busy=0, out_valid=0.
  - STREAM: busy=1, out_valid=1.
- Load acceptance:
  - Accepted when in IDLE, or in STREAM on the same cycle as a last-beat handshake (out_valid & out_ready & out_last), giving back-to-back bursts.
  - On accept, register line_in, start_idx, byte_mask, and remaining=len.
  - Next cycle: STREAM, out_idx=start_idx, out_word = line word start_idx (bits 16*i+15 : 16*i), masked per Optional Feature.
  - Latency from load to first out_valid is 1 cycle.
- Load ignored: a load in STREAM that does not coincide with a last-beat handshake. Buffer and burst are unaffected, and load_drop pulses high for 1 cycle (the cycle after).
- Handshake:
  - A beat transfers when out_valid & out_ready.
  - While out_valid & !out_ready: out_word, out_idx and out_last hold stable.
- Advance on a transfer with remaining != 0:
  - out_idx <= out_idx+1 mod 8 (7 wraps to 0).
  - remaining <= remaining-1.
  - out_word is the unmasked full word at the new index.
- out_last = (remaining == 0), combinational from state.
- Burst end: a transfer with out_last=1 returns to IDLE (out_valid=0 next cycle), unless a load is accepted that cycle, in which case the FSM stays in STREAM with the new burst.
- Wrap: start_idx=6, len=3 yields indices 6, 7, 0, 1.
- Outputs are registered; there is no combinational path from out_ready to out_valid.
- Input values are don't-care when load=0.

Optional Feature:
- Macro: LINE_WORD_READER_BYTE_MASK_EN.
- Defined: the first beat of each burst is masked by the captured byte_mask; subsequent beats are full words.
  - 01: out_word = {8'h00, line[16i+7 : 16i]}.
  - 10: out_word = {line[16i+15 : 16i+8], 8'h00}.
  - 11 or 00: full word.
- Not defined: byte_mask is ignored and every beat is the full word.

Test Plan:
Line pattern for all tests: word k = {8'hA0+k, 8'h10+k}, so word3 = 16'hA313.
1. Reset mid-burst: load start_idx=2, len=7; deassert rst_n during the 3rd beat -> out_valid=0 and busy=0 immediately; after release, out_valid stays 0 until the next load.
2. Full wrap: load start_idx=5, len=7, out_ready=1 -> out_idx 5,6,7,0,1,2,3,4 on consecutive cycles; first word 16'hA515; out_last only on idx 4; idle after.
3. Backpressure: start_idx=1, len=2, out_ready low for 3 cycles on beat 2 -> out_word holds 16'hA212 and out_idx=2 throughout; then idx 3 with out_last=1.
4. Back-to-back: load asserted on the last-beat handshake of burst A (start 0, len 0) with burst B (start 7, len 1) -> next cycle out_idx=7 with no idle gap; out_idx 7 then 0. A load mid-burst (not last beat) -> load_drop=1 for one cycle and the burst is unaffected.
5. Byte mask (macro defined): start_idx=3, byte_mask=10, len=1 -> 16'hA300, then 16'hA414. byte_mask=01 -> 16'h0013. Macro undefined -> 16'hA313 in both cases.
